// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default sizes and Gray-code helpers
// used by the read side, the write side and the storage block.
package fifo_pkg;

  localparam int DSIZE_DEF       = 8;
  localparam int ASIZE_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int PTR_MAX_W       = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Callers zero-extend their ASIZE+1 pointer into ptr_t and truncate the result,
  // so one pair of functions serves every pointer width.
  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = '0;
    for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready stream carrying popped words from the read controller to the consumer.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
);

  logic             rd_valid;
  logic [DSIZE-1:0] rd_data;
  logic             rd_ready;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/fifo_rd_ctrl_sync.sv
// Multi-bit flop chain carrying a Gray pointer into this clock domain.
// Only one bit changes per pointer step, so no logic sits between the stages.
module sync_w2r
  import fifo_pkg::*;
#(
  parameter int WIDTH  = ASIZE_DEF + 1,
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_q[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_q[i] <= r_q[i-1];
      end
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: pointers, synchronized write pointer,
// registered empty flag and a one-entry show-ahead output register.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE       = DSIZE_DEF,
  parameter int ASIZE       = ASIZE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   wptr_gray,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr_gray,
  output logic             rempty,
  output logic [ASIZE:0]   rlevel,
  fifo_rd_ctrl_if.master   rdIf
);

  localparam int PW = ASIZE + 1;

  logic [PW-1:0]    r_rbin;
  logic [PW-1:0]    r_rgray;
  logic             r_rempty;
  logic             r_rdValid;
  logic [DSIZE-1:0] r_rdData;

  logic [PW-1:0]    w_wqS;
  logic [PW-1:0]    w_rbinNext;
  logic [PW-1:0]    w_rgrayNext;
  logic             w_pop;

  sync_w2r #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_syncW2r (
    .clk (rclk),
    .rst (rrst),
    .i_d (wptr_gray),
    .o_q (w_wqS)
  );

  // Pop whenever storage has a word and the output register is free or being drained.
  assign w_pop       = !r_rempty && (!r_rdValid || rdIf.rd_ready);
  assign w_rbinNext  = r_rbin + PW'(w_pop);
  assign w_rgrayNext = PW'(bin2gray(ptr_t'(w_rbinNext)));

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rbin   <= '0;
      r_rgray  <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbinNext;
      r_rgray  <= w_rgrayNext;
      r_rempty <= (w_rgrayNext == w_wqS);
    end
  end

  // Show-ahead register: loads on pop, empties when consumed without a refill.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else if (w_pop) begin
      r_rdValid <= 1'b1;
      r_rdData  <= mem_rdata;
    end else if (r_rdValid && rdIf.rd_ready) begin
      r_rdValid <= 1'b0;
    end
  end

  assign raddr         = r_rbin[ASIZE-1:0];
  assign rptr_gray     = r_rgray;
  assign rempty        = r_rempty;
  assign rlevel        = PW'(gray2bin(ptr_t'(w_wqS))) - r_rbin;
  assign rdIf.rd_valid = r_rdValid;
  assign rdIf.rd_data  = r_rdData;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a cycle table for single-word and back-pressure
// traffic, hand-written wrap/full-depth/reset sequences, and a scoreboard on the stream.
module tb_fifo_rd_ctrl;

  logic       rclk;
  logic       rrst;
  logic [4:0] wptr_gray;
  logic [7:0] mem_rdata;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic       rempty;
  logic [4:0] rlevel;

  fifo_rd_ctrl_if #(.DSIZE(8)) rdIf ();

  fifo_rd_ctrl #(
    .DSIZE       (8),
    .ASIZE       (4),
    .SYNC_STAGES (2)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .wptr_gray (wptr_gray),
    .mem_rdata (mem_rdata),
    .raddr     (raddr),
    .rptr_gray (rptr_gray),
    .rempty    (rempty),
    .rlevel    (rlevel),
    .rdIf      (rdIf)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [7:0] mem [16];
  assign mem_rdata = mem[raddr];

  int checks;
  int errors;
  logic [4:0] wbin;
  logic [7:0] expQ [$];

  typedef struct {
    int         nWr;
    logic [7:0] wrBase;
    logic       ready;
    logic       expValid;
    logic       expEmpty;
    logic [4:0] expLevel;
    logic [7:0] expData;
    logic [4:0] expRptr;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writer model: store the word, advance the write pointer and expect the word downstream.
  task automatic writeWord(input logic [7:0] data);
    mem[wbin[3:0]] = data;
    wbin = wbin + 5'd1;
    wptr_gray = wbin ^ (wbin >> 1);
    expQ.push_back(data);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int k = 0; k < v.nWr; k++) begin
      writeWord(v.wrBase + 8'(8'h11 * k));
    end
    rdIf.rd_ready = v.ready;
  endtask

  task automatic stepEdge();
    @(posedge rclk);
    #1;
  endtask

  task automatic drainQueue(input string name, input int limit);
    for (int i = 0; i < limit && expQ.size() != 0; i++) begin
      stepEdge();
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  // Scoreboard: a word is transferred at the edge following a negedge with valid && ready.
  always @(negedge rclk) begin
    if (!rrst && rdIf.rd_valid && rdIf.rd_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected word", {24'd0, rdIf.rd_data}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("stream data", {24'd0, rdIf.rd_data}, {24'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    wbin = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    //            nWr  base   rdy val emp lvl    data   rptr
    vecs[0]  = '{1, 8'hA5, 1'b1, 0, 1, 5'd0, 8'h00, 5'b00000};
    vecs[1]  = '{0, 8'h00, 1'b1, 0, 1, 5'd1, 8'h00, 5'b00000};
    vecs[2]  = '{0, 8'h00, 1'b1, 0, 0, 5'd1, 8'h00, 5'b00000};
    vecs[3]  = '{0, 8'h00, 1'b1, 1, 1, 5'd0, 8'hA5, 5'b00001};
    vecs[4]  = '{0, 8'h00, 1'b1, 0, 1, 5'd0, 8'hA5, 5'b00001};
    vecs[5]  = '{3, 8'h11, 1'b0, 0, 1, 5'd0, 8'hA5, 5'b00001};
    vecs[6]  = '{0, 8'h00, 1'b0, 0, 1, 5'd3, 8'hA5, 5'b00001};
    vecs[7]  = '{0, 8'h00, 1'b0, 0, 0, 5'd3, 8'hA5, 5'b00001};
    vecs[8]  = '{0, 8'h00, 1'b0, 1, 0, 5'd2, 8'h11, 5'b00011};
    vecs[9]  = '{0, 8'h00, 1'b0, 1, 0, 5'd2, 8'h11, 5'b00011};
    vecs[10] = '{0, 8'h00, 1'b0, 1, 0, 5'd2, 8'h11, 5'b00011};
    vecs[11] = '{0, 8'h00, 1'b1, 1, 0, 5'd1, 8'h22, 5'b00010};
    vecs[12] = '{0, 8'h00, 1'b1, 1, 1, 5'd0, 8'h33, 5'b00110};
    vecs[13] = '{0, 8'h00, 1'b1, 0, 1, 5'd0, 8'h33, 5'b00110};

    // Reset held with a nonzero write pointer: nothing may leak through.
    rrst = 1'b1;
    wptr_gray = 5'b00011;
    rdIf.rd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      stepEdge();
      checkOutput("reset rempty", rempty, 1);
      checkOutput("reset rd_valid", rdIf.rd_valid, 0);
      checkOutput("reset rptr_gray", rptr_gray, 0);
      checkOutput("reset rd_data", rdIf.rd_data, 0);
    end
    wptr_gray = 5'b00000;
    rrst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      stepEdge();
      checkOutput($sformatf("vec%0d rd_valid", i), rdIf.rd_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d rempty", i), rempty, vecs[i].expEmpty);
      checkOutput($sformatf("vec%0d rlevel", i), rlevel, vecs[i].expLevel);
      checkOutput($sformatf("vec%0d rd_data", i), rdIf.rd_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d rptr_gray", i), rptr_gray, vecs[i].expRptr);
    end
    checkOutput("table raddr", raddr, 4);
    checkOutput("table queue", expQ.size(), 0);

    // Restart both sides from zero pointers for the full-depth and wrap sequence.
    rdIf.rd_ready = 1'b0;
    rrst = 1'b1;
    stepEdge();
    wbin = '0;
    wptr_gray = '0;
    expQ.delete();
    rrst = 1'b0;

    for (int i = 0; i < 16; i++) writeWord(8'h40 + 8'(i));
    stepEdge();
    stepEdge();
    checkOutput("full rlevel", rlevel, 16);
    checkOutput("full rempty pre", rempty, 1);
    stepEdge();
    checkOutput("full rlevel edge3", rlevel, 16);
    checkOutput("full rempty", rempty, 0);
    rdIf.rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      stepEdge();
      checkOutput($sformatf("drain rlevel %0d", i), rlevel, 5'(16 - i));
    end
    checkOutput("wrap rempty", rempty, 1);
    checkOutput("wrap rptr_gray", rptr_gray, 5'b11000);
    checkOutput("wrap raddr", raddr, 0);
    stepEdge();
    checkOutput("full drained", expQ.size(), 0);
    checkOutput("full rd_valid low", rdIf.rd_valid, 0);

    for (int i = 0; i < 4; i++) writeWord(8'hC0 + 8'(i));
    drainQueue("wrap drain", 12);
    stepEdge();
    checkOutput("wrap2 rptr_gray", rptr_gray, 5'b11110);
    checkOutput("wrap2 rempty", rempty, 1);
    checkOutput("wrap2 rd_valid", rdIf.rd_valid, 0);

    // Mid-stream reset with a word parked in the output register.
    rdIf.rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) writeWord(8'h60 + 8'(i));
    for (int c = 0; c < 4; c++) stepEdge();
    checkOutput("pre-reset rd_valid", rdIf.rd_valid, 1);
    checkOutput("pre-reset rlevel", rlevel, 5);
    #2;
    rrst = 1'b1;
    #1;
    checkOutput("async rd_valid", rdIf.rd_valid, 0);
    checkOutput("async rptr_gray", rptr_gray, 0);
    checkOutput("async raddr", raddr, 0);
    checkOutput("async rempty", rempty, 1);
    checkOutput("async rlevel", rlevel, 0);
    expQ.delete();
    wbin = '0;
    wptr_gray = '0;
    stepEdge();
    rrst = 1'b0;

    rdIf.rd_ready = 1'b1;
    writeWord(8'h77);
    writeWord(8'h88);
    drainQueue("post-reset drain", 12);
    stepEdge();
    checkOutput("post-reset rempty", rempty, 1);
    checkOutput("post-reset rptr_gray", rptr_gray, 5'b00011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
